wb_stage: RTL and testbench

Registered writeback stage for the RISC-V core. It is the parametrised successor of the single-cycle combinational writeback select.
- Accepts one retiring instruction per handshake and selects its result source: ALU, load data, link address or LUI immediate.
- For loads, waits a variable number of cycles for memory read data, then sign- or zero-extends it.
- Drives the register-file write port and a forwarding tap.

---
 rtl/wb_stage_pkg.sv | 16 +
 rtl/load_ext.sv | 22 ++
 rtl/wb_stage.sv | 110 +++++++++++
 tb/tb_wb_stage.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_stage_pkg.sv
// wb_stage_pkg: shared encodings and bus widths for the writeback stage
package wb_stage_pkg;
  localparam int REG_BUS = 32;
  localparam int INST_BUS = 32;
  localparam int INST_ADDR_BUS = 10;
  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_LINK = 2'b10;
  localparam logic [1:0] WB_LUI = 2'b11;
  localparam logic [2:0] LB = 3'b000;
  localparam logic [2:0] LH = 3'b001;
  localparam logic [2:0] LW = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  typedef enum logic {WB_IDLE = 1'b0, WB_WAIT_MEM = 1'b1} wb_state_t;
endpackage

// File: rtl/load_ext.sv
// load_ext: extracts the addressed byte/half of a load word and sign/zero-extends it
module load_ext
  import wb_stage_pkg::*;
#(
  parameter int XLEN = REG_BUS
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      offset,
  input  logic [XLEN-1:0] word,
  output logic [XLEN-1:0] data
);
  logic [7:0] b;
  logic [15:0] h;
  always_comb begin
    b = word[{offset, 3'b000} +: 8];
    h = offset[1] ? word[31:16] : word[15:0];
    data = funct3 == LB  ? {{(XLEN-8){b[7]}}, b} :
           funct3 == LBU ? {{(XLEN-8){1'b0}}, b} :
           funct3 == LH  ? {{(XLEN-16){h[15]}}, h} :
           funct3 == LHU ? {{(XLEN-16){1'b0}}, h} : word;
  end
endmodule

// File: rtl/wb_stage.sv
// wb_stage: registered writeback select with load wait/timeout; WB_LOAD_EXT_EN enables byte/half load extension
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int XLEN = REG_BUS,
  parameter int PC_W = INST_ADDR_BUS,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      wb_sel,
  input  logic            reg_we,
  input  logic [4:0]      rd,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] alu_result,
  input  logic [PC_W-1:0] pc,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic [4:0]      busy_rd,
  output logic            load_err
);
  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  wb_state_t state;
  logic [CNT_W-1:0] cnt;
  logic [4:0] cap_rd;
  logic cap_we;
  logic [PC_W-1:0] link_pc;
  logic [XLEN-1:0] result, load_data;
  logic accept_load;
  logic unused;
  assign unused = ^instr[11:0];
  assign link_pc = pc + PC_W'(4);
  assign accept_load = state == WB_IDLE && in_valid && wb_sel == WB_MEM;
  always_comb result = wb_sel == WB_LINK ? XLEN'(link_pc) :
                       wb_sel == WB_LUI  ? XLEN'({instr[31:12], 12'b0}) : alu_result;
`ifdef WB_LOAD_EXT_EN
  logic [2:0] cap_f3;
  logic [1:0] cap_off;
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_f3 <= '0;
      cap_off <= '0;
    end else if (accept_load) begin
      cap_f3 <= instr[14:12];
      cap_off <= alu_result[1:0];
    end
  end
  load_ext #(.XLEN(XLEN)) u_load_ext (
    .funct3(cap_f3),
    .offset(cap_off),
    .word(mem_rdata),
    .data(load_data)
  );
`else
  assign load_data = mem_rdata;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= WB_IDLE;
      cnt <= '0;
      cap_rd <= '0;
      cap_we <= 1'b0;
      in_ready <= 1'b1;
      rf_we <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      busy_rd <= '0;
      load_err <= 1'b0;
    end else begin
      rf_we <= 1'b0;
      load_err <= 1'b0;
      if (state == WB_IDLE) begin
        if (accept_load) begin
          state <= WB_WAIT_MEM;
          cnt <= '0;
          cap_rd <= rd;
          cap_we <= reg_we;
          in_ready <= 1'b0;
          busy_rd <= rd;
        end else if (in_valid && reg_we && rd != 5'd0) begin
          rf_we <= 1'b1;
          rf_waddr <= rd;
          rf_wdata <= result;
        end
      end else if (mem_rvalid) begin
        state <= WB_IDLE;
        in_ready <= 1'b1;
        busy_rd <= '0;
        if (cap_we && cap_rd != 5'd0) begin
          rf_we <= 1'b1;
          rf_waddr <= cap_rd;
          rf_wdata <= load_data;
        end
      end else if (cnt == CNT_W'(MEM_TIMEOUT - 1)) begin
        // data that arrives in this same cycle is taken by the branch above
        state <= WB_IDLE;
        in_ready <= 1'b1;
        busy_rd <= '0;
        load_err <= 1'b1;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: vector table, hand sequences and randomized model check of wb_stage
module tb_wb_stage;
  localparam int TMO = 15;
  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, in_ready;
  logic [1:0] wb_sel = 2'b00;
  logic reg_we = 1'b0;
  logic [4:0] rd = 5'd0;
  logic [31:0] instr = '0, alu_result = '0, mem_rdata = '0;
  logic [9:0] pc = '0;
  logic mem_rvalid = 1'b0;
  logic rf_we, load_err;
  logic [4:0] rf_waddr, busy_rd;
  logic [31:0] rf_wdata;
  int total = 0, bad = 0;

  wb_stage #(.XLEN(32), .PC_W(10), .MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .wb_sel(wb_sel), .reg_we(reg_we), .rd(rd), .instr(instr),
    .alu_result(alu_result), .pc(pc), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .busy_rd(busy_rd), .load_err(load_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] sel;
    logic we;
    logic [4:0] rd;
    logic [31:0] instr;
    logic [31:0] alu;
    logic [9:0] pc;
    logic ewe;
    logic [31:0] edata;
  } vec_t;
  vec_t vt[7];

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_load(input logic [4:0] r, input logic [2:0] f3, input logic [1:0] off, input logic rv);
    in_valid = 1'b1;
    wb_sel = 2'b01;
    reg_we = 1'b1;
    rd = r;
    instr = {17'b0, f3, 12'h003};
    alu_result = {30'h0, off};
    mem_rvalid = rv;
    step;
    in_valid = 1'b0;
    mem_rvalid = 1'b0;
  endtask

  function automatic logic [31:0] ref_result(logic [1:0] sel, logic [31:0] ins, logic [31:0] alu, logic [9:0] p);
    if (sel == 2'b10) return 32'((int'(p) + 4) % 1024);
    if (sel == 2'b11) return ins & 32'hFFFFF000;
    return alu;
  endfunction

  function automatic logic [31:0] ref_load(logic [2:0] f3, logic [1:0] off, logic [31:0] w);
    int v;
    v = 0;
`ifdef WB_LOAD_EXT_EN
    if (f3 == 3'b000 || f3 == 3'b100) begin
      v = int'((w >> (8 * off)) & 32'hFF);
      if (f3 == 3'b000 && v > 127) v -= 256;
      return 32'(v);
    end
    if (f3 == 3'b001 || f3 == 3'b101) begin
      v = int'((w >> (16 * (off / 2))) & 32'hFFFF);
      if (f3 == 3'b001 && v > 32767) v -= 65536;
      return 32'(v);
    end
`endif
    return w + 32'(v);
  endfunction

  initial begin
    logic [31:0] last_data;
    logic [4:0] last_addr;
    bit busy;
    int waited;
    logic [4:0] p_rd;
    logic p_we;
    logic [2:0] p_f3;
    logic [1:0] p_off;
    logic e_we, e_err, e_ready;
    logic [4:0] e_waddr, e_busy;
    logic [31:0] e_wdata;
    logic [2:0] f3s[5];

    vt[0] = '{2'b00, 1'b1, 5'd5, 32'h0, 32'h0000_1234, 10'h0, 1'b1, 32'h0000_1234};
    vt[1] = '{2'b00, 1'b1, 5'd6, 32'h0, 32'hFFFF_0000, 10'h0, 1'b1, 32'hFFFF_0000};
    vt[2] = '{2'b10, 1'b1, 5'd1, 32'h0, 32'h0, 10'h3FC, 1'b1, 32'h0000_0000};
    vt[3] = '{2'b11, 1'b1, 5'd1, 32'hABCD_E0B7, 32'h0, 10'h0, 1'b1, 32'hABCD_E000};
    vt[4] = '{2'b00, 1'b1, 5'd0, 32'h0, 32'h0000_0055, 10'h0, 1'b0, 32'h0};
    vt[5] = '{2'b10, 1'b0, 5'd3, 32'h0, 32'h0, 10'h010, 1'b0, 32'h0};
    vt[6] = '{2'b10, 1'b1, 5'd31, 32'h0, 32'h0, 10'h100, 1'b1, 32'h0000_0104};

    step;
    step;
    chk("reset rf_we", rf_we, 0);
    chk("reset rf_waddr", rf_waddr, 0);
    chk("reset rf_wdata", rf_wdata, 0);
    chk("reset busy_rd", busy_rd, 0);
    chk("reset load_err", load_err, 0);
    chk("reset in_ready", in_ready, 1);
    rst = 1'b0;

    last_data = '0;
    last_addr = '0;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      wb_sel = vt[i].sel;
      reg_we = vt[i].we;
      rd = vt[i].rd;
      instr = vt[i].instr;
      alu_result = vt[i].alu;
      pc = vt[i].pc;
      step;
      if (vt[i].ewe) begin
        last_data = vt[i].edata;
        last_addr = vt[i].rd;
      end
      chk($sformatf("vec%0d rf_we", i), rf_we, vt[i].ewe);
      chk($sformatf("vec%0d rf_waddr", i), rf_waddr, last_addr);
      chk($sformatf("vec%0d rf_wdata", i), rf_wdata, last_data);
      chk($sformatf("vec%0d in_ready", i), in_ready, 1);
    end
    in_valid = 1'b0;
    step;
    chk("idle rf_we", rf_we, 0);

    do_load(5'd7, 3'b010, 2'd0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      chk("lw wait in_ready", in_ready, 0);
      chk("lw wait busy_rd", busy_rd, 7);
      chk("lw wait rf_we", rf_we, 0);
      step;
    end
    mem_rvalid = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    step;
    mem_rvalid = 1'b0;
    chk("lw rf_we", rf_we, 1);
    chk("lw rf_waddr", rf_waddr, 7);
    chk("lw rf_wdata", rf_wdata, 32'hDEAD_BEEF);
    chk("lw busy_rd", busy_rd, 0);
    chk("lw in_ready", in_ready, 1);

    do_load(5'd8, 3'b000, 2'd3, 1'b0);
    mem_rvalid = 1'b1;
    mem_rdata = 32'h80FF_FFFF;
    step;
    mem_rvalid = 1'b0;
`ifdef WB_LOAD_EXT_EN
    chk("lb off3", rf_wdata, 32'hFFFF_FF80);
`else
    chk("lb off3 raw", rf_wdata, 32'h80FF_FFFF);
`endif
    do_load(5'd8, 3'b101, 2'd2, 1'b0);
    mem_rvalid = 1'b1;
    mem_rdata = 32'h8001_1234;
    step;
    mem_rvalid = 1'b0;
`ifdef WB_LOAD_EXT_EN
    chk("lhu off2", rf_wdata, 32'h0000_8001);
`else
    chk("lhu off2 raw", rf_wdata, 32'h8001_1234);
`endif

    do_load(5'd9, 3'b010, 2'd0, 1'b1);
    chk("accept ignores rvalid rf_we", rf_we, 0);
    chk("accept ignores rvalid in_ready", in_ready, 0);
    for (int k = 1; k <= TMO; k++) begin
      step;
      if (k < TMO) begin
        chk("tmo early load_err", load_err, 0);
        chk("tmo early in_ready", in_ready, 0);
      end else begin
        chk("tmo load_err", load_err, 1);
        chk("tmo rf_we", rf_we, 0);
        chk("tmo in_ready", in_ready, 1);
        chk("tmo busy_rd", busy_rd, 0);
      end
    end
    step;
    chk("tmo pulse ends", load_err, 0);

    do_load(5'd11, 3'b010, 2'd0, 1'b0);
    repeat (TMO - 1) step;
    mem_rvalid = 1'b1;
    mem_rdata = 32'h1234_5678;
    step;
    mem_rvalid = 1'b0;
    chk("limit rf_we", rf_we, 1);
    chk("limit rf_waddr", rf_waddr, 11);
    chk("limit rf_wdata", rf_wdata, 32'h1234_5678);
    chk("limit load_err", load_err, 0);

    do_load(5'd12, 3'b010, 2'd0, 1'b0);
    step;
    rst = 1'b1;
    step;
    rst = 1'b0;
    chk("rst mid rf_we", rf_we, 0);
    chk("rst mid rf_wdata", rf_wdata, 0);
    chk("rst mid busy_rd", busy_rd, 0);
    chk("rst mid in_ready", in_ready, 1);
    chk("rst mid load_err", load_err, 0);
    mem_rvalid = 1'b1;
    step;
    mem_rvalid = 1'b0;
    chk("late rvalid rf_we", rf_we, 0);
    chk("late rvalid load_err", load_err, 0);

    rst = 1'b1;
    step;
    rst = 1'b0;
    busy = 0;
    waited = 0;
    p_rd = '0; p_we = 0; p_f3 = '0; p_off = '0;
    e_we = 0; e_err = 0; e_ready = 1; e_waddr = '0; e_busy = '0; e_wdata = '0;
    f3s = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    for (int n = 0; n < 600; n++) begin
      in_valid = 1'($urandom % 2);
      wb_sel = 2'($urandom % 4);
      reg_we = ($urandom % 4) != 0;
      rd = 5'($urandom % 32);
      instr = $urandom;
      instr[14:12] = f3s[$urandom % 5];
      alu_result = $urandom;
      pc = 10'($urandom % 1024);
      mem_rvalid = ($urandom % 8) == 0;
      mem_rdata = $urandom;
      e_we = 0;
      e_err = 0;
      if (!busy) begin
        if (in_valid && wb_sel == 2'b01) begin
          busy = 1; waited = 0;
          p_rd = rd; p_we = reg_we; p_f3 = instr[14:12]; p_off = alu_result[1:0];
          e_busy = rd; e_ready = 0;
        end else if (in_valid && reg_we && rd != 0) begin
          e_we = 1; e_waddr = rd;
          e_wdata = ref_result(wb_sel, instr, alu_result, pc);
        end
      end else if (mem_rvalid) begin
        busy = 0; e_busy = 0; e_ready = 1;
        if (p_we && p_rd != 0) begin
          e_we = 1; e_waddr = p_rd; e_wdata = ref_load(p_f3, p_off, mem_rdata);
        end
      end else begin
        waited++;
        if (waited == TMO) begin
          busy = 0; e_busy = 0; e_ready = 1; e_err = 1;
        end
      end
      step;
      chk("rnd rf_we", rf_we, e_we);
      chk("rnd rf_waddr", rf_waddr, e_waddr);
      chk("rnd rf_wdata", rf_wdata, e_wdata);
      chk("rnd busy_rd", busy_rd, e_busy);
      chk("rnd load_err", load_err, e_err);
      chk("rnd in_ready", in_ready, e_ready);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
